// File: rtl/serial_addsub_unit.sv
// Bit-serial adder/subtractor: one full-adder slice plus a carry flip-flop, LSB first.
// Add computes A+B+Cin; subtract computes B+~A+Cin (B-A when Cin=1). Results are modulo 2^WIDTH.
module serial_addsub_unit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sel,
    input  logic             Cin,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             carry
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t state;
    state_t next_state;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             c_ff;
    logic [CW-1:0]    cnt;
    logic             sum_bit;
    logic             cnext;

    assign sum_bit = a_sr[0] ^ b_sr[0] ^ c_ff;
    assign cnext   = (a_sr[0] & b_sr[0]) | (a_sr[0] & c_ff) | (b_sr[0] & c_ff);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (start) next_state = S_SHIFT;
            S_SHIFT: if (cnt == LAST_BIT) next_state = S_DONE;
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Subtract mode stores ~A up front, so the shift loop is a plain adder either way.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            c_ff   <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            out    <= '0;
            carry  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_sr <= sel ? ~A : A;
                        b_sr <= B;
                        c_ff <= Cin;
                        cnt  <= '0;
                        busy <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= {sum_bit, res_sr[WIDTH-1:1]};
                    c_ff   <= cnext;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST_BIT) begin
                        out   <= {sum_bit, res_sr[WIDTH-1:1]};
                        carry <= cnext;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    done <= 1'b0;
                end
                default: begin
                    busy <= 1'b0;
                    done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_addsub_unit.sv
// Directed bench for serial_addsub_unit: a WIDTH=4 instance for cycle-exact scenarios
// and a WIDTH=8 instance for a long run against an arithmetic reference.
module tb_serial_addsub_unit;

    logic       clk;
    logic       rst_n;

    logic       start4, sel4, cin4;
    logic [3:0] a4, b4;
    logic       busy4, done4, carry4;
    logic [3:0] out4;

    logic       start8, sel8, cin8;
    logic [7:0] a8, b8;
    logic       busy8, done8, carry8;
    logic [7:0] out8;

    int checks = 0;
    int errors = 0;

    serial_addsub_unit #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .sel(sel4), .Cin(cin4),
        .A(a4), .B(b4), .busy(busy4), .done(done4), .out(out4), .carry(carry4)
    );

    serial_addsub_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .sel(sel8), .Cin(cin8),
        .A(a8), .B(b8), .busy(busy8), .done(done8), .out(out8), .carry(carry8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a negedge; launches one op and checks every cycle up to the return to IDLE.
    task automatic run_op4(input logic [3:0] a, input logic [3:0] b, input logic s,
                           input logic ci, input logic [3:0] exp_out,
                           input logic exp_c, input string name);
        a4 = a; b4 = b; sel4 = s; cin4 = ci; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (busy4 !== 1'b1 || done4 !== 1'b0) begin
                errors++;
                $display("[TB] FAIL %s busy cycle %0d: busy=%b done=%b, required busy=1 done=0",
                         name, i, busy4, done4);
            end
            if (i < 3) @(negedge clk);
        end
        @(negedge clk);
        checks++;
        if (done4 !== 1'b1 || busy4 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s done pulse: done=%b busy=%b, required done=1 busy=0",
                     name, done4, busy4);
        end
        checks++;
        if (out4 !== exp_out || carry4 !== exp_c) begin
            errors++;
            $display("[TB] FAIL %s result: out=%0d carry=%b, required out=%0d carry=%b",
                     name, out4, carry4, exp_out, exp_c);
        end
        @(negedge clk);
        checks++;
        if (done4 !== 1'b0 || out4 !== exp_out || carry4 !== exp_c) begin
            errors++;
            $display("[TB] FAIL %s hold: done=%b out=%0d carry=%b, required done=0 out=%0d carry=%b",
                     name, done4, out4, carry4, exp_out, exp_c);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start4 = 1'b0; sel4 = 1'b0; cin4 = 1'b0; a4 = '0; b4 = '0;
        start8 = 1'b0; sel8 = 1'b0; cin8 = 1'b0; a8 = '0; b8 = '0;
        #1;
        checks++;
        if (busy4 !== 1'b0 || done4 !== 1'b0 || out4 !== 4'd0 || carry4 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset state: busy=%b done=%b out=%0d carry=%b, required all 0",
                     busy4, done4, out4, carry4);
        end
        #11;
        rst_n = 1'b1;
        @(negedge clk);
        run_op4(4'd3, 4'd5, 1'b0, 1'b0, 4'd8, 1'b0, "add_3_5");
    endtask

    task automatic test_add_back_to_back();
        run_op4(4'd7,  4'd6, 1'b0, 1'b0, 4'd13, 1'b0, "add_7_6");
        run_op4(4'd9,  4'd4, 1'b0, 1'b0, 4'd13, 1'b0, "add_9_4");
        run_op4(4'd12, 4'd7, 1'b0, 1'b1, 4'd4,  1'b1, "add_12_7_cin");
    endtask

    task automatic test_subtract();
        run_op4(4'd3, 4'd5, 1'b1, 1'b1, 4'd2,  1'b1, "sub_5_3");
        run_op4(4'd6, 4'd4, 1'b1, 1'b1, 4'd14, 1'b0, "sub_4_6_borrow");
        run_op4(4'd2, 4'd9, 1'b1, 1'b1, 4'd7,  1'b1, "sub_9_2");
        run_op4(4'd3, 4'd5, 1'b1, 1'b0, 4'd1,  1'b1, "sub_ones_comp");
    endtask

    // start stays high through SHIFT and DONE while operands churn; only one op may run.
    task automatic test_inputs_while_busy();
        int done_count = 0;
        int busy_count = 0;
        a4 = 4'd15; b4 = 4'd15; sel4 = 1'b0; cin4 = 1'b1; start4 = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done4 === 1'b1) done_count++;
            if (busy4 === 1'b1) busy_count++;
            a4 = 4'(i); b4 = ~4'(i); sel4 = ~sel4; cin4 = ~cin4;
            start4 = (i < 5);
        end
        checks++;
        if (done_count != 1) begin
            errors++;
            $display("[TB] FAIL busy_inputs done count: got %0d, required 1", done_count);
        end
        checks++;
        if (busy_count != 4) begin
            errors++;
            $display("[TB] FAIL busy_inputs busy cycles: got %0d, required 4", busy_count);
        end
        checks++;
        if (out4 !== 4'd15 || carry4 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL busy_inputs result: out=%0d carry=%b, required out=15 carry=1",
                     out4, carry4);
        end
    endtask

    task automatic test_reset_mid_op();
        int done_count = 0;
        start4 = 1'b0;
        @(negedge clk);
        a4 = 4'd5; b4 = 4'd10; sel4 = 1'b0; cin4 = 1'b0; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy4 !== 1'b0 || done4 !== 1'b0 || out4 !== 4'd0 || carry4 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid_op: busy=%b done=%b out=%0d carry=%b, required all 0",
                     busy4, done4, out4, carry4);
        end
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done4 === 1'b1 || busy4 === 1'b1) done_count++;
        end
        checks++;
        if (done_count != 0) begin
            errors++;
            $display("[TB] FAIL reset_mid_op activity after abort: %0d cycles, required 0",
                     done_count);
        end
        run_op4(4'd1, 4'd1, 1'b0, 1'b0, 4'd2, 1'b0, "after_reset_1_1");
    endtask

    task automatic test_random_w8();
        logic [8:0] expv;
        int         waited;
        for (int n = 0; n < 500; n++) begin
            a8 = 8'($urandom_range(0, 255));
            b8 = 8'($urandom_range(0, 255));
            sel8 = 1'($urandom_range(0, 1));
            cin8 = 1'($urandom_range(0, 1));
            if (sel8) expv = {1'b0, b8} + {1'b0, ~a8} + {8'd0, cin8};
            else      expv = {1'b0, b8} + {1'b0, a8}  + {8'd0, cin8};
            start8 = 1'b1;
            @(negedge clk);
            start8 = 1'b0;
            waited = 0;
            while (done8 !== 1'b1 && waited < 20) begin
                @(negedge clk);
                waited++;
            end
            checks++;
            if (done8 !== 1'b1 || out8 !== expv[7:0] || carry8 !== expv[8]) begin
                errors++;
                $display("[TB] FAIL w8 op %0d (A=%0d B=%0d sel=%b cin=%b): done=%b out=%0d carry=%b, required out=%0d carry=%b",
                         n, a8, b8, sel8, cin8, done8, out8, carry8, expv[7:0], expv[8]);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_add_back_to_back();
        test_subtract();
        test_inputs_while_busy();
        test_reset_mid_op();
        @(negedge clk);
        test_random_w8();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
